// File: rtl/adcdac_ctrl_pkg.sv
// Shared types for the ZDOK serial control link: FSM state encoding and status bit positions.
package adcdac_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } link_state_t;

    localparam int STAT_FRAME_ERR  = 0;
    localparam int STAT_PARITY_ERR = 1;
    localparam int STAT_RX_OVF     = 2;
    localparam int STAT_TX_OVF     = 3;

endpackage

// File: rtl/adcdac_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted when a pop frees a slot.
module adcdac_ctrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero when empty so the output is defined out of reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/adcdac_ctrl_link.sv
// UART-style control link to the ADC/DAC mezzanine: FIFO-buffered TX/RX serialisers,
// optional even parity, sticky error status and internal loopback.
module adcdac_ctrl_link
    import adcdac_ctrl_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 8,
    parameter int PARITY_EN  = 1
) (
    input  logic              fpga_clk,
    input  logic              fpga_rst_n,
    output logic              zdok_tx_data,
    input  logic              zdok_rx_data,
    input  logic              loopback,
    input  logic [DATA_W-1:0] user_tx_data,
    input  logic              user_tx_val,
    output logic              user_tx_full,
    output logic [DATA_W-1:0] user_rx_data,
    output logic              user_rx_val,
    input  logic              user_rx_rd,
    output logic              user_rx_full,
    output logic [3:0]        status,
    input  logic              status_clr
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
    localparam logic [IW-1:0] IDX_END  = IW'(DATA_W - 1);
    localparam bit            HAS_PAR  = (PARITY_EN != 0);

    // TX side
    link_state_t       tx_state;
    logic [CW-1:0]     tx_cnt;
    logic [IW-1:0]     tx_idx;
    logic [DATA_W-1:0] tx_shift;
    logic              tx_par, tx_line;
    logic [DATA_W-1:0] tx_head;
    logic              tx_empty, tx_full, tx_pop;

    assign tx_pop = !tx_empty &&
                    (tx_state == ST_IDLE || (tx_state == ST_STOP && tx_cnt == BIT_END));

    adcdac_ctrl_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (fpga_clk),
        .rst_n (fpga_rst_n),
        .push  (user_tx_val),
        .pop   (tx_pop),
        .din   (user_tx_data),
        .dout  (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    tx_cnt <= '0;
                    if (!tx_empty) begin
                        tx_state <= ST_START;
                        tx_line  <= 1'b0;
                        tx_shift <= tx_head;
                        tx_par   <= ^tx_head;
                    end
                end
                ST_START: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_state <= ST_DATA;
                        tx_line  <= tx_shift[0];
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                ST_DATA: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        if (tx_idx == IDX_END) begin
                            tx_state <= HAS_PAR ? ST_PARITY : ST_STOP;
                            tx_line  <= HAS_PAR ? tx_par : 1'b1;
                        end else begin
                            tx_idx   <= tx_idx + 1'b1;
                            tx_shift <= tx_shift >> 1;
                            tx_line  <= tx_shift[1];
                        end
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                ST_PARITY: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt   <= '0;
                        tx_state <= ST_STOP;
                        tx_line  <= 1'b1;
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                ST_STOP: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        // Chain straight into the next start bit so queued words go out gap-free.
                        if (!tx_empty) begin
                            tx_state <= ST_START;
                            tx_line  <= 1'b0;
                            tx_shift <= tx_head;
                            tx_par   <= ^tx_head;
                        end else begin
                            tx_state <= ST_IDLE;
                            tx_line  <= 1'b1;
                        end
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                default: begin
                    tx_state <= ST_IDLE;
                    tx_line  <= 1'b1;
                end
            endcase
        end
    end

    assign zdok_tx_data = tx_line;
    assign user_tx_full = tx_full;

    // RX front end: source select latched only between frames, then a 2-flop synchroniser.
    logic lb_sel, rx_src, rx_s1, rx_s2, rx_prev;

    assign rx_src = lb_sel ? tx_line : zdok_rx_data;

    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_src;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    link_state_t       rx_state;
    logic [CW-1:0]     rx_cnt;
    logic [IW-1:0]     rx_idx;
    logic [DATA_W-1:0] rx_shift;
    logic              rx_par, rx_brk, rx_push;
    logic              rx_empty, rx_full, rx_stop_hit, parity_bad;

    assign parity_bad  = HAS_PAR && ((^rx_shift) != rx_par);
    assign rx_stop_hit = (rx_state == ST_STOP) && !rx_brk && (rx_cnt == BIT_END);

    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_par   <= 1'b0;
            rx_brk   <= 1'b0;
            rx_push  <= 1'b0;
            lb_sel   <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            case (rx_state)
                ST_IDLE: begin
                    lb_sel <= loopback;
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s2) rx_state <= ST_START;
                end
                ST_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                ST_DATA: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
                        if (rx_idx == IDX_END) rx_state <= HAS_PAR ? ST_PARITY : ST_STOP;
                        else                   rx_idx   <= rx_idx + 1'b1;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                ST_PARITY: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_par   <= rx_s2;
                        rx_state <= ST_STOP;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                ST_STOP: begin
                    // After a bad stop bit, hold here until the line returns high (break).
                    if (rx_brk) begin
                        if (rx_s2) begin
                            rx_brk   <= 1'b0;
                            rx_state <= ST_IDLE;
                        end
                    end else if (rx_cnt == BIT_END) begin
                        rx_cnt <= '0;
                        if (!rx_s2) rx_brk <= 1'b1;
                        else begin
                            rx_state <= ST_IDLE;
                            rx_push  <= !parity_bad;
                        end
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    adcdac_ctrl_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (fpga_clk),
        .rst_n (fpga_rst_n),
        .push  (rx_push),
        .pop   (user_rx_rd),
        .din   (rx_shift),
        .dout  (user_rx_data),
        .empty (rx_empty),
        .full  (rx_full)
    );

    assign user_rx_val  = !rx_empty;
    assign user_rx_full = rx_full;

    logic [3:0] status_set;

    always_comb begin
        status_set                  = '0;
        status_set[STAT_FRAME_ERR]  = rx_stop_hit && !rx_s2;
        status_set[STAT_PARITY_ERR] = rx_stop_hit && rx_s2 && parity_bad;
        status_set[STAT_RX_OVF]     = rx_push && rx_full && !(user_rx_rd && !rx_empty);
        status_set[STAT_TX_OVF]     = user_tx_val && tx_full && !tx_pop;
    end

    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) status <= '0;
        else             status <= (status & {4{~status_clr}}) | status_set;
    end

endmodule

// File: tb/tb_adcdac_ctrl_link.sv
// Directed bench for adcdac_ctrl_link: loopback, FIFO limits, external framing/parity errors, reset.
module tb_adcdac_ctrl_link;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int CLK_DIV   = 8;
    localparam int PARITY_EN = 1;
    localparam int F         = (DATA_W + 2 + PARITY_EN) * CLK_DIV;

    logic              fpga_clk = 1'b0;
    logic              fpga_rst_n = 1'b0;
    logic              zdok_tx_data;
    logic              zdok_rx_data = 1'b1;
    logic              loopback = 1'b0;
    logic [DATA_W-1:0] user_tx_data = '0;
    logic              user_tx_val = 1'b0;
    logic              user_tx_full;
    logic [DATA_W-1:0] user_rx_data;
    logic              user_rx_val;
    logic              user_rx_rd = 1'b0;
    logic              user_rx_full;
    logic [3:0]        status;
    logic              status_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 fpga_clk = ~fpga_clk;

    adcdac_ctrl_link #(
        .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .PARITY_EN(PARITY_EN)
    ) dut (
        .fpga_clk     (fpga_clk),
        .fpga_rst_n   (fpga_rst_n),
        .zdok_tx_data (zdok_tx_data),
        .zdok_rx_data (zdok_rx_data),
        .loopback     (loopback),
        .user_tx_data (user_tx_data),
        .user_tx_val  (user_tx_val),
        .user_tx_full (user_tx_full),
        .user_rx_data (user_rx_data),
        .user_rx_val  (user_rx_val),
        .user_rx_rd   (user_rx_rd),
        .user_rx_full (user_rx_full),
        .status       (status),
        .status_clr   (status_clr)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge fpga_clk);
    endtask

    task automatic push_word(input logic [7:0] w);
        user_tx_data = w;
        user_tx_val  = 1'b1;
        tick(1);
        user_tx_val  = 1'b0;
    endtask

    task automatic pop_rx();
        user_rx_rd = 1'b1;
        tick(1);
        user_rx_rd = 1'b0;
    endtask

    task automatic clear_status();
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
    endtask

    task automatic wait_rx(input int budget, output int waited);
        waited = 0;
        while (user_rx_val !== 1'b1 && waited < budget) begin
            tick(1);
            waited++;
        end
    endtask

    // Drive one frame on the external RX line, optionally corrupting parity or stop.
    task automatic send_ext(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        zdok_rx_data = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            zdok_rx_data = d[i];
            tick(CLK_DIV);
        end
        zdok_rx_data = (^d) ^ bad_par;
        tick(CLK_DIV);
        zdok_rx_data = ~bad_stop;
        tick(CLK_DIV);
        zdok_rx_data = 1'b1;
        tick(2 * CLK_DIV);
    endtask

    task automatic test_reset();
        fpga_rst_n = 1'b0;
        tick(3);
        checks++;
        if (zdok_tx_data !== 1'b1) begin errors++; $display("FAIL reset_tx_line: got %b want 1", zdok_tx_data); end
        checks++;
        if (user_rx_val !== 1'b0 || user_rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_rx: val %b data %h want 0/00", user_rx_val, user_rx_data);
        end
        checks++;
        if (user_tx_full !== 1'b0 || user_rx_full !== 1'b0) begin
            errors++; $display("FAIL reset_full: tx %b rx %b want 0/0", user_tx_full, user_rx_full);
        end
        checks++;
        if (status !== 4'h0) begin errors++; $display("FAIL reset_status: got %h want 0", status); end
        fpga_rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_loopback_single();
        int w;
        loopback = 1'b1;
        tick(2);
        push_word(8'hA5);
        wait_rx(F + 6, w);
        checks++;
        if (user_rx_val !== 1'b1 || w > F + 6) begin
            errors++; $display("FAIL lb_latency: val %b after %0d cycles want 1 within %0d", user_rx_val, w, F + 6);
        end
        checks++;
        if (user_rx_data !== 8'hA5) begin errors++; $display("FAIL lb_data: got %h want a5", user_rx_data); end
        checks++;
        if (status !== 4'h0) begin errors++; $display("FAIL lb_status: got %h want 0", status); end
        pop_rx();
        checks++;
        if (user_rx_val !== 1'b0) begin errors++; $display("FAIL lb_pop: val %b want 0", user_rx_val); end
    endtask

    task automatic test_tx_full();
        int w;
        tick(2 * CLK_DIV);
        for (int i = 0; i < 17; i++) push_word(8'(8'h10 + i));
        checks++;
        if (user_tx_full !== 1'b1) begin errors++; $display("FAIL txfull_flag: got %b want 1", user_tx_full); end
        for (int i = 0; i < 17; i++) begin
            wait_rx(2 * F, w);
            checks++;
            if (user_rx_val !== 1'b1 || user_rx_data !== 8'(8'h10 + i)) begin
                errors++;
                $display("FAIL txfull_word%0d: val %b data %h want 1/%h", i, user_rx_val, user_rx_data, 8'(8'h10 + i));
            end
            pop_rx();
        end
        checks++;
        if (status !== 4'h0) begin errors++; $display("FAIL txfull_status: got %h want 0", status); end
    endtask

    task automatic test_rx_ovf();
        int n;
        tick(2 * CLK_DIV);
        clear_status();
        for (int i = 0; i < 20; i++) begin
            n = 0;
            while (user_tx_full === 1'b1 && n < 2 * F) begin
                tick(1);
                n++;
            end
            push_word(8'(8'h40 + i));
        end
        tick(18 * F);
        checks++;
        if (status !== 4'b0100) begin errors++; $display("FAIL rxovf_status: got %b want 0100", status); end
        checks++;
        if (user_rx_full !== 1'b1) begin errors++; $display("FAIL rxovf_full: got %b want 1", user_rx_full); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (user_rx_val !== 1'b1 || user_rx_data !== 8'(8'h40 + i)) begin
                errors++;
                $display("FAIL rxovf_word%0d: val %b data %h want 1/%h", i, user_rx_val, user_rx_data, 8'(8'h40 + i));
            end
            pop_rx();
        end
        checks++;
        if (user_rx_val !== 1'b0) begin errors++; $display("FAIL rxovf_drained: val %b want 0", user_rx_val); end
    endtask

    task automatic test_frame_err();
        int w;
        loopback = 1'b0;
        tick(4);
        clear_status();
        send_ext(8'h3C, 1'b0, 1'b1);
        checks++;
        if (status !== 4'b0001) begin errors++; $display("FAIL frame_status: got %b want 0001", status); end
        checks++;
        if (user_rx_val !== 1'b0) begin errors++; $display("FAIL frame_nopush: val %b want 0", user_rx_val); end
        send_ext(8'h3C, 1'b0, 1'b0);
        wait_rx(2 * F, w);
        checks++;
        if (user_rx_val !== 1'b1 || user_rx_data !== 8'h3C) begin
            errors++; $display("FAIL frame_recover: val %b data %h want 1/3c", user_rx_val, user_rx_data);
        end
        pop_rx();
    endtask

    task automatic test_parity_glitch();
        clear_status();
        send_ext(8'h01, 1'b1, 1'b0);
        checks++;
        if (status !== 4'b0010) begin errors++; $display("FAIL parity_status: got %b want 0010", status); end
        checks++;
        if (user_rx_val !== 1'b0) begin errors++; $display("FAIL parity_nopush: val %b want 0", user_rx_val); end
        zdok_rx_data = 1'b0;
        tick(2);
        zdok_rx_data = 1'b1;
        tick(F + 2 * CLK_DIV);
        checks++;
        if (user_rx_val !== 1'b0) begin errors++; $display("FAIL glitch_nopush: val %b want 0", user_rx_val); end
        checks++;
        if (status !== 4'b0010) begin errors++; $display("FAIL glitch_status: got %b want 0010", status); end
    endtask

    task automatic test_reset_mid_frame();
        int w;
        loopback = 1'b1;
        tick(4);
        push_word(8'h00);
        push_word(8'h22);
        push_word(8'h33);
        tick(3 * CLK_DIV);
        fpga_rst_n = 1'b0;
        #1;
        checks++;
        if (zdok_tx_data !== 1'b1) begin errors++; $display("FAIL rstmid_tx_line: got %b want 1", zdok_tx_data); end
        checks++;
        if (user_rx_val !== 1'b0 || status !== 4'h0) begin
            errors++; $display("FAIL rstmid_clear: val %b status %h want 0/0", user_rx_val, status);
        end
        tick(3);
        fpga_rst_n = 1'b1;
        tick(2 * F);
        checks++;
        if (user_rx_val !== 1'b0 || zdok_tx_data !== 1'b1) begin
            errors++; $display("FAIL rstmid_fifo_empty: val %b tx %b want 0/1", user_rx_val, zdok_tx_data);
        end
        push_word(8'h5A);
        wait_rx(F + 6, w);
        checks++;
        if (user_rx_val !== 1'b1 || user_rx_data !== 8'h5A) begin
            errors++; $display("FAIL rstmid_after: val %b data %h want 1/5a", user_rx_val, user_rx_data);
        end
        checks++;
        if (status !== 4'h0) begin errors++; $display("FAIL rstmid_status: got %h want 0", status); end
        pop_rx();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(1);
        test_reset();
        test_loopback_single();
        test_tx_full();
        test_rx_ovf();
        test_frame_err();
        test_parity_glitch();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
